// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its inverse decoder.
package fib_pkg;

    // Search/handshake states shared by the Fibonacci blocks.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } fib_state_e;

    // Largest index whose Fibonacci number fits in 32 bits, and that number.
    localparam int unsigned FIB_MAX_IDX_32 = 47;
    localparam logic [31:0] FIB_MAX_VAL_32 = 32'd2971215073;

endpackage : fib_pkg

// File: rtl/fib_index_decoder.sv
// Fibonacci index decoder: decides whether a captured value is a Fibonacci
// number by walking the sequence one term per cycle, and reports its index.
//
// Ports:
//   clk    - clock, all logic on posedge
//   rst    - synchronous active-high reset
//   start  - request, sampled only while idle
//   value  - operand, captured on the accepted start edge
//   busy   - high while searching and during the done cycle
//   done   - one-cycle pulse when is_fib/index are valid
//   is_fib - value equals some F(k)
//   index  - hit: smallest k with F(k)=value; miss: smallest k with
//            F(k)>value, or MAX_IDX+1 when no representable term exceeds it
module fib_index_decoder
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned MAX_IDX = FIB_MAX_IDX_32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] index
);

    fib_state_e       state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             is_fib_d;
    logic [IDX_W-1:0] index_d;
    logic [WIDTH:0]   sum;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath step and result decisions.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        is_fib_d = is_fib;
        index_d  = index;
        sum      = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = value;
                    a_d      = '0;
                    b_d      = WIDTH'(1);
                    k_d      = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                if (a_q == target_q) begin
                    is_fib_d = 1'b1;
                    index_d  = k_q;
                    state_d  = DONE;
                end else if (a_q > target_q) begin
                    is_fib_d = 1'b0;
                    index_d  = k_q;
                    state_d  = DONE;
                end else if (k_q == IDX_W'(MAX_IDX)) begin
                    is_fib_d = 1'b0;
                    index_d  = IDX_W'(MAX_IDX + 1);
                    state_d  = DONE;
                end else begin
                    a_d = b_q;
                    // Saturate the term past the last representable one; it
                    // only ever lands in b and is never compared against.
                    b_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                    k_d = k_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            a_q      <= '0;
            b_q      <= WIDTH'(1);
            k_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_fib   <= 1'b0;
            index    <= '0;
        end else begin
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            is_fib   <= is_fib_d;
            index    <= index_d;
        end
    end

endmodule : fib_index_decoder

// File: tb/tb_fib_index_decoder.sv
// Self-checking bench for fib_index_decoder: a table-driven lookup model with
// a latency countdown is compared against the DUT on every cycle, plus
// directed cases with hand-computed indices and latencies.
module tb_fib_index_decoder;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned MAX_IDX = 47;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             busy;
    logic             done;
    logic             is_fib;
    logic [IDX_W-1:0] index;

    fib_index_decoder #(
        .WIDTH  (WIDTH),
        .IDX_W  (IDX_W),
        .MAX_IDX(MAX_IDX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .is_fib(is_fib),
        .index (index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    longint unsigned fibt [0:48];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference lookup straight from the definition of the outputs.
    task automatic ref_lookup(input logic [31:0] v, output int idx, output bit hit);
        idx = int'(MAX_IDX) + 1;
        hit = 1'b0;
        for (int k = 0; k <= int'(MAX_IDX); k++) begin
            if (fibt[k] == longint'(v)) begin
                idx = k; hit = 1'b1; return;
            end
            if (fibt[k] > longint'(v)) begin
                idx = k; hit = 1'b0; return;
            end
        end
    endtask

    function automatic int latency_of(input int idx);
        return ((idx > int'(MAX_IDX)) ? int'(MAX_IDX) : idx) + 1;
    endfunction

    // Cycle model: accepted start -> busy for latency cycles, then a done cycle.
    int m_phase = 0;
    int m_rem   = 0;
    int p_idx   = 0;
    bit p_hit   = 1'b0;
    bit m_busy = 1'b0, m_done = 1'b0, m_fib = 1'b0;
    int m_idx = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_busy = 1'b0; m_done = 1'b0; m_fib = 1'b0; m_idx = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    ref_lookup(value, p_idx, p_hit);
                    m_rem = latency_of(p_idx);
                    m_phase = 1; m_busy = 1'b1;
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_phase = 2; m_done = 1'b1; m_fib = p_hit; m_idx = p_idx;
                    end
                end
                default: begin
                    m_phase = 0; m_busy = 1'b0; m_done = 1'b0;
                end
            endcase
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle busy",   64'(busy),   64'(m_busy));
            chk("cycle done",   64'(done),   64'(m_done));
            chk("cycle is_fib", 64'(is_fib), 64'(m_fib));
            chk("cycle index",  64'(index),  64'(m_idx));
        end
    end

    task automatic go(input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; value = v;
        @(negedge clk);
        start = 1'b0; value = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 100);
        if (!done) chk("done timeout", 64'(cyc), 64'(0));
    endtask

    task automatic run(input string name, input logic [31:0] v,
                       input int exp_idx, input bit exp_fib, input int exp_lat);
        int cyc;
        go(v);
        wait_done(cyc);
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, " is_fib"}, 64'(is_fib), 64'(exp_fib));
        chk({name, " index"}, 64'(index), 64'(exp_idx));
    endtask

    initial begin
        int idx, cyc;
        bit hit;
        logic [31:0] v;

        fibt[0] = 0; fibt[1] = 1;
        for (int k = 2; k <= 48; k++) fibt[k] = fibt[k-1] + fibt[k-2];

        // Pin the model to hand-computed values.
        chk("model F47", longint'(fibt[47]), 64'd2971215073);
        ref_lookup(32'd13, idx, hit);
        chk("model 13 idx", 64'(idx), 64'd7);
        ref_lookup(32'd4, idx, hit);
        chk("model 4 idx", 64'(idx), 64'd5);
        chk("model 4 hit", 64'(hit), 64'd0);
        ref_lookup(32'hFFFF_FFFF, idx, hit);
        chk("model max idx", 64'(idx), 64'd48);

        // Reset, then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset busy",  64'(busy),  64'd0);
        chk("reset index", 64'(index), 64'd0);
        repeat (5) @(negedge clk);

        // Directed corner values.
        run("v0", 32'd0, 0, 1'b1, 1);
        run("v1", 32'd1, 1, 1'b1, 2);
        run("v13", 32'd13, 7, 1'b1, 8);
        repeat (10) @(negedge clk);
        chk("hold is_fib", 64'(is_fib), 64'd1);
        chk("hold index",  64'(index),  64'd7);
        run("v4", 32'd4, 5, 1'b0, 6);
        repeat (10) @(negedge clk);
        chk("hold4 index", 64'(index), 64'd5);
        run("vF47", 32'd2971215073, 47, 1'b1, 48);
        run("vmax", 32'hFFFF_FFFF, 48, 1'b0, 48);

        // start while busy is ignored.
        go(32'd21);
        repeat (2) @(negedge clk);
        start = 1'b1; value = 32'd8;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("busy-start index",  64'(index),  64'd8);
        chk("busy-start is_fib", 64'(is_fib), 64'd1);
        // start held through the done cycle; accepted once idle.
        start = 1'b1; value = 32'd5;
        @(negedge clk);
        chk("done-start ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("idle-start accepted", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("v5 index", 64'(index), 64'd5);

        // Reset mid-search.
        go(32'd832040);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy",   64'(busy),   64'd0);
        chk("midrst done",   64'(done),   64'd0);
        chk("midrst is_fib", 64'(is_fib), 64'd0);
        chk("midrst index",  64'(index),  64'd0);
        repeat (40) @(negedge clk);
        run("v832040", 32'd832040, 30, 1'b1, 31);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0: v = $urandom;
                1: v = 32'(fibt[$urandom_range(47)]);
                2: v = 32'(fibt[$urandom_range(47)]) + ($urandom_range(1) ? 32'd1 : 32'hFFFF_FFFF);
                default: v = $urandom_range(200);
            endcase
            go(v);
            cyc = 0;
            while (!done && cyc < 100) begin
                @(negedge clk);
                cyc++;
                start = ($urandom_range(3) == 0);
                value = $urandom;
                if (t % 9 == 4 && cyc == 5) rst = 1'b1;
                else rst = 1'b0;
                if (t % 9 == 4 && cyc == 8) break;
            end
            start = 1'b0; rst = 1'b0;
            if (cyc >= 100) chk("random timeout", 64'(cyc), 64'(0));
            repeat ($urandom_range(60, 50)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fib_index_decoder

// File: doc/fib_index_decoder.md
Name: fib_index_decoder

Overview:
Inverse of the team's Fibonacci sequence generator. The generator maps an index to F(n); this block takes a 32-bit value and decides whether it is a Fibonacci number, and if so returns its index n. It walks the sequence iteratively behind a start/busy/done handshake. Verification benches use it to check the generator's stream, and control logic uses it for index lookup.

Parameters:
WIDTH, 32, value width in bits
IDX_W, 6, index width; must hold MAX_IDX+1
MAX_IDX, 47, largest k with F(k) < 2^WIDTH (F(47)=2971215073 for WIDTH=32)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
value  input  WIDTH  operand; captured on the accepted start edge
busy  output  1  high in SEARCH and DONE
done  output  1  one-cycle pulse when the result is valid
is_fib  output  1  1 if the captured value equals some F(k)
index  output  IDX_W  on hit: smallest k with F(k)=value; on miss: smallest k with F(k)>value, or MAX_IDX+1 if none fits

Behaviour:
- Reset, at any time including mid-search: state=IDLE. busy=0, done=0, is_fib=0, index=0. Internal a=0, b=1, k=0. No done pulse follows a reset.
- Fibonacci convention: F(0)=0, F(1)=1. Value 1 reports index 1, not 2.
- IDLE:
  - start=1 at edge E0: target<=value, a<=0, b<=1, k<=0, state<=SEARCH.
  - start=0: hold state. is_fib and index keep their last result.
- SEARCH, one comparison per edge:
  - a==target: is_fib<=1, index<=k, go to DONE.
  - a>target: is_fib<=0, index<=k, go to DONE.
  - a<target and k==MAX_IDX: is_fib<=0, index<=MAX_IDX+1, go to DONE.
  - otherwise: a<=b, b<=a+b, k<=k+1.
- Overflow handling: compute a+b at WIDTH+1 bits. If the carry is set, store all-ones in b. Decisions never depend on a value above F(MAX_IDX+1).
- DONE: done=1 for exactly one cycle, then state goes to IDLE. is_fib and index stay stable until the next accepted start.
- Latency:
  - Hit at F(k), or miss at first F(k)>value: done is high in the cycle after edge E(k+1), i.e. k+1 cycles after the start edge.
  - Worst case is value > F(MAX_IDX): latency MAX_IDX+1 = 48.
- start while busy=1 (SEARCH or DONE) is ignored. value may change freely once captured.
- Arithmetic is unsigned only.

Decomposition:
- Shared package fib_pkg holds:
  - state enum {IDLE, SEARCH, DONE}
  - FIB_MAX_IDX_32=47
  - FIB_MAX_VAL_32=32'd2971215073
- The generator and this decoder both import fib_pkg.
- Single module. The a/b/k step is too small to justify a sub-module.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, is_fib=0, index=0 throughout.
- start with value=0 -> done 1 cycle after the start edge, is_fib=1, index=0. value=1 -> latency 2, is_fib=1, index=1.
- value=13 -> done after 8 cycles, is_fib=1, index=7. value=4 -> done after 6 cycles, is_fib=0, index=5. Both results held stable for 10 idle cycles after done.
- value=2971215073 -> latency 48, is_fib=1, index=47. value=32'hFFFFFFFF -> latency 48, is_fib=0, index=48. No spurious hit from the saturated b.
- value=21 started, start pulsed with value=8 while busy -> ignored, result is index=8, is_fib=1. start held high in the DONE cycle -> ignored; the next start in IDLE is accepted.
- rst asserted mid-search of value=832040 -> next cycle is IDLE with all outputs 0 and no done pulse. A fresh start of the same value -> index=30, is_fib=1.
